// File: rtl/regfile_writeback.sv
// Write-side controller for the register file: buffers ALU and load results in an
// in-order FIFO, drains one write per cycle and tracks outstanding writes per register.
module regfile_writeback #(
  parameter int BIT_NUMBER      = 64,
  parameter int ADDR_NUMBER     = 5,
  parameter int REGISTER_NUMBER = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         alu_valid_i,
  output logic                         alu_ready_o,
  input  logic [ADDR_NUMBER-1:0]       alu_dest_i,
  input  logic [BIT_NUMBER-1:0]        alu_data_i,
  input  logic                         mem_valid_i,
  output logic                         mem_ready_o,
  input  logic [ADDR_NUMBER-1:0]       mem_dest_i,
  input  logic [BIT_NUMBER-1:0]        mem_data_i,
  input  logic                         issue_valid_i,
  input  logic [ADDR_NUMBER-1:0]       issue_dest_i,
  output logic                         write_enable_o,
  output logic [ADDR_NUMBER-1:0]       dest_addr_o,
  output logic [BIT_NUMBER-1:0]        write_data_o,
  output logic [REGISTER_NUMBER-1:0]   pending_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
  output logic                         addr_error_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  // One extra bit so REGISTER_NUMBER == 2**ADDR_NUMBER still compares correctly.
  localparam logic [ADDR_NUMBER:0] REG_LIMIT = (ADDR_NUMBER + 1)'(REGISTER_NUMBER);
  localparam logic [CW-1:0]        DEPTH     = CW'(FIFO_DEPTH);

  logic [ADDR_NUMBER-1:0]     dest_mem [FIFO_DEPTH];
  logic [BIT_NUMBER-1:0]      data_mem [FIFO_DEPTH];

  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]              alu_slot;
  logic [CW-1:0]              count_q, count_d;
  logic [CW-1:0]              free_slots, enq_cnt;
  logic [REGISTER_NUMBER-1:0] pending_q, pending_d;
  logic                       err_q, err_d;
  logic                       we_q;
  logic [ADDR_NUMBER-1:0]     dest_q;
  logic [BIT_NUMBER-1:0]      data_q;

  logic                       mem_acc, alu_acc;
  logic                       mem_ok, alu_ok, issue_ok;
  logic                       deq;
  logic [ADDR_NUMBER-1:0]     head_dest;

  // Readiness looks only at the registered count; a same-cycle pop is not credited.
  always_comb begin
    free_slots  = DEPTH - count_q;
    mem_ready_o = (free_slots >= CW'(1));
    alu_ready_o = (free_slots >= CW'(2)) || ((free_slots >= CW'(1)) && !mem_valid_i);
  end

  always_comb begin
    mem_acc   = mem_valid_i && mem_ready_o;
    alu_acc   = alu_valid_i && alu_ready_o;
    mem_ok    = mem_acc && ({1'b0, mem_dest_i} < REG_LIMIT);
    alu_ok    = alu_acc && ({1'b0, alu_dest_i} < REG_LIMIT);
    issue_ok  = issue_valid_i && ({1'b0, issue_dest_i} < REG_LIMIT);
    deq       = (count_q != '0);
    head_dest = dest_mem[rd_ptr_q];
    enq_cnt   = CW'(mem_ok) + CW'(alu_ok);
    alu_slot  = wr_ptr_q + PW'(mem_ok);
    wr_ptr_d  = wr_ptr_q + PW'(mem_ok) + PW'(alu_ok);
    rd_ptr_d  = rd_ptr_q + PW'(deq);
    count_d   = count_q + enq_cnt - CW'(deq);
    err_d     = err_q | (mem_acc & ~mem_ok) | (alu_acc & ~alu_ok) | (issue_valid_i & ~issue_ok);
  end

  // A set from issue overrides a clear from the dequeuing head on the same register.
  for (genvar gi = 0; gi < REGISTER_NUMBER; gi++) begin : g_pending
    localparam logic [ADDR_NUMBER-1:0] REG_ADDR = ADDR_NUMBER'(gi);
    assign pending_d[gi] = (issue_valid_i && (issue_dest_i == REG_ADDR)) ||
                           (pending_q[gi] && !(deq && (head_dest == REG_ADDR)));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      dest_q    <= '0;
      data_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      we_q      <= deq;
      if (deq) begin
        dest_q <= head_dest;
        data_q <= data_mem[rd_ptr_q];
      end
    end
  end

  // Mem entry takes the first free slot, the ALU entry the one after it.
  always_ff @(posedge clk_i) begin
    if (mem_ok) begin
      dest_mem[wr_ptr_q] <= mem_dest_i;
      data_mem[wr_ptr_q] <= mem_data_i;
    end
    if (alu_ok) begin
      dest_mem[alu_slot] <= alu_dest_i;
      data_mem[alu_slot] <= alu_data_i;
    end
  end

  assign write_enable_o = we_q;
  assign dest_addr_o    = dest_q;
  assign write_data_o   = data_q;
  assign pending_o      = pending_q;
  assign fifo_count_o   = count_q;
  assign addr_error_o   = err_q;

endmodule
